// File: rtl/hack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hack_pkg: shared widths, reset PC and fetch FSM state encoding.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package hack_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;

   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      STREAM   = 2'd1,
      STALL    = 2'd2,
      REDIRECT = 2'd3
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_skid_buf: 1-entry instr+pc holding buffer with full flag,    |
// | built only when FETCH_SKID_EN is defined.                          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fetch_skid_buf #(
   parameter int ADDR_W = hack_pkg::ADDR_W,
   parameter int DATA_W = hack_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] instr_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              full_o,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] pc_o
);

   logic              full_q,  full_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] pc_q,    pc_d;

   always_comb begin
      full_d  = full_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush_i) begin
         full_d = 1'b0;
      end else if (push_i) begin
         full_d  = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end else if (pop_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full_q  <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         full_q  <= full_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign full_o  = full_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/hack_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hack_fetch_stage: Hack CPU PC, 1-cycle sync ROM driver and         |
// | valid/ready instruction output. FETCH_SKID_EN adds a skid entry.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module hack_fetch_stage #(
   parameter int                ADDR_W   = hack_pkg::ADDR_W,
   parameter int                DATA_W   = hack_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = hack_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc
);

   import hack_pkg::*;

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   fetch_state_e      state_q,     state_d;
   logic [ADDR_W-1:0] pc_q,        pc_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_pc_q,    out_pc_d;

   logic              w_stall;
   logic              w_fl_valid;
   logic [ADDR_W-1:0] w_fl_pc;
   logic              w_src_valid;
   logic [DATA_W-1:0] w_src_instr;
   logic [ADDR_W-1:0] w_src_pc;
   logic [ADDR_W-1:0] w_stall_pc;

   assign w_stall    = out_valid_q && !out_ready;
   // The ROM word is wanted only if the previous edge issued a fetch,
   // which is exactly when that edge left the FSM in STREAM.
   assign w_fl_valid = (state_q == STREAM);
   assign w_fl_pc    = pc_q - PC_ONE;

`ifdef FETCH_SKID_EN
   logic              w_skid_push;
   logic              w_skid_pop;
   logic              w_skid_full;
   logic [DATA_W-1:0] w_skid_instr;
   logic [ADDR_W-1:0] w_skid_pc;

   assign w_skid_push = !jump && w_stall && w_fl_valid;
   assign w_skid_pop  = !jump && !w_stall && w_skid_full;
   assign w_src_valid = w_skid_full || w_fl_valid;
   assign w_src_instr = w_skid_full ? w_skid_instr : rom_data;
   assign w_src_pc    = w_skid_full ? w_skid_pc : w_fl_pc;
   assign w_stall_pc  = pc_q;

   fetch_skid_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (jump),
      .push_i  (w_skid_push),
      .pop_i   (w_skid_pop),
      .instr_i (rom_data),
      .pc_i    (w_fl_pc),
      .full_o  (w_skid_full),
      .instr_o (w_skid_instr),
      .pc_o    (w_skid_pc)
   );
`else
   assign w_src_valid = w_fl_valid;
   assign w_src_instr = rom_data;
   assign w_src_pc    = w_fl_pc;
   // In-flight word is dropped, so refetch starts right after the held one.
   assign w_stall_pc  = out_pc_q + PC_ONE;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      if (jump) begin
         state_d     = REDIRECT;
         pc_d        = jump_target;
         out_valid_d = 1'b0;
      end else if (w_stall) begin
         state_d = STALL;
         pc_d    = w_stall_pc;
      end else begin
         state_d     = STREAM;
         pc_d        = pc_q + PC_ONE;
         out_valid_d = w_src_valid;
         if (w_src_valid) begin
            out_instr_d = w_src_instr;
            out_pc_d    = w_src_pc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign rom_addr  = pc_q;
   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_pc    = out_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_fetch_stage.sv
`default_nettype none
// Bench for hack_fetch_stage: program-order scoreboard with redirect latency
// and stall-bubble rules, directed scenarios pinned by literals, then random traffic.
module tb_hack_fetch_stage;

   localparam int             AW     = 15;
   localparam int             DW     = 16;
   localparam logic [AW-1:0]  RST_PC = 15'h0000;

   logic          clk         = 1'b0;
   logic          reset_n     = 1'b1;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic          jump        = 1'b0;
   logic [AW-1:0] jump_target = '0;
   logic          out_valid;
   logic          out_ready   = 1'b0;
   logic [DW-1:0] out_instr;
   logic [AW-1:0] out_pc;

   int vec  = 0;
   int miss = 0;

   hack_fetch_stage #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .RESET_PC (RST_PC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .jump        (jump),
      .jump_target (jump_target),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      return 16'h1000 + {1'b0, a};
   endfunction

   logic [AW-1:0] rom_q = '0;
   always @(posedge clk) rom_q <= rom_addr;
   assign rom_data = rom_word(rom_q);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: words leave in program order; a redirect empties the output for
   // two edges; a stall holds the word; without a skid entry, the edge that
   // releases a stall is followed by one empty cycle.
   int            r;
   logic [AW-1:0] nxt;
   logic          mv;
   logic [AW-1:0] mpc;
   logic [DW-1:0] minstr;
   logic          pstl;
   logic          hs, stl, newv;

   logic          pin_en    = 1'b0;
   logic [AW-1:0] pin_pc    = '0;
   logic [DW-1:0] pin_instr = '0;

   always begin
      @(negedge clk or negedge reset_n);
      #1;
      if (!reset_n) begin
         r = 0; nxt = RST_PC; mv = 1'b0; mpc = '0; minstr = '0; pstl = 1'b0;
         chk("reset_valid", {31'd0, out_valid}, 32'd0);
         chk("reset_rom_addr", {17'd0, rom_addr}, {17'd0, RST_PC});
         chk("reset_pc", {17'd0, out_pc}, 32'd0);
         chk("reset_instr", {16'd0, out_instr}, 32'd0);
      end else begin
         hs  = mv && out_ready;
         stl = mv && !out_ready && !jump;
         if (jump) begin
            r = 0; nxt = jump_target; mv = 1'b0; pstl = 1'b0;
            chk("redirect_rom_addr", {17'd0, rom_addr}, {17'd0, jump_target});
         end else begin
            if (r < 2) r++;
            newv = (r >= 2);
`ifndef FETCH_SKID_EN
            if (hs && pstl) newv = 1'b0;
`endif
            if (!stl) begin
               if (newv) begin
                  mpc    = nxt;
                  minstr = rom_word(nxt);
                  nxt    = nxt + 15'd1;
                  mv     = 1'b1;
               end else begin
                  mv = 1'b0;
               end
            end
            pstl = stl;
         end
         chk("valid", {31'd0, out_valid}, {31'd0, mv});
         if (mv) begin
            chk("pc", {17'd0, out_pc}, {17'd0, mpc});
            chk("instr", {16'd0, out_instr}, {16'd0, minstr});
         end
         if (pin_en) begin
            chk("pin_valid", {31'd0, out_valid}, 32'd1);
            chk("pin_pc", {17'd0, out_pc}, {17'd0, pin_pc});
            chk("pin_instr", {16'd0, out_instr}, {16'd0, pin_instr});
         end
      end
   end

   task automatic tick(input logic j, input logic [AW-1:0] t, input logic rdy);
      jump        = j;
      jump_target = t;
      out_ready   = rdy;
      @(negedge clk);
      #2;
      pin_en = 1'b0;
   endtask

   task automatic tick_pin(input logic j, input logic [AW-1:0] t, input logic rdy,
                           input logic [AW-1:0] pc, input logic [DW-1:0] instr);
      pin_pc    = pc;
      pin_instr = instr;
      pin_en    = 1'b1;
      tick(j, t, rdy);
   endtask

   initial begin
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;

      // boot: first word after the 2nd edge, then one per cycle
      tick(1'b0, '0, 1'b1);
      for (int i = 0; i <= 5; i++)
         tick_pin(1'b0, '0, 1'b1, AW'(i), 16'h1000 + 16'(i));

      // stall holding pc 5
      repeat (3) tick_pin(1'b0, '0, 1'b0, 15'h0005, 16'h1005);
`ifdef FETCH_SKID_EN
      tick_pin(1'b0, '0, 1'b1, 15'h0006, 16'h1006);
      tick_pin(1'b0, '0, 1'b1, 15'h0007, 16'h1007);
`else
      tick(1'b0, '0, 1'b1);
      tick_pin(1'b0, '0, 1'b1, 15'h0006, 16'h1006);
`endif

      // jump to 0x0040
      tick(1'b1, 15'h0040, 1'b1);
      tick(1'b0, '0, 1'b1);
      tick_pin(1'b0, '0, 1'b1, 15'h0040, 16'h1040);
      tick_pin(1'b0, '0, 1'b1, 15'h0041, 16'h1041);

      // jump coinciding with a handshake at pc 9
      tick(1'b1, 15'h0009, 1'b1);
      tick(1'b0, '0, 1'b1);
      tick_pin(1'b0, '0, 1'b1, 15'h0009, 16'h1009);
      tick(1'b1, 15'h0100, 1'b1);
      tick(1'b0, '0, 1'b1);
      tick_pin(1'b0, '0, 1'b1, 15'h0100, 16'h1100);

      // address wrap
      tick(1'b1, 15'h7FFE, 1'b1);
      tick(1'b0, '0, 1'b1);
      tick_pin(1'b0, '0, 1'b1, 15'h7FFE, 16'h8FFE);
      tick_pin(1'b0, '0, 1'b1, 15'h7FFF, 16'h8FFF);
      tick_pin(1'b0, '0, 1'b1, 15'h0000, 16'h1000);
      tick_pin(1'b0, '0, 1'b1, 15'h0001, 16'h1001);

      // jump while stalled drops the held word
      tick(1'b0, '0, 1'b0);
      tick(1'b0, '0, 1'b0);
      tick(1'b1, 15'h0200, 1'b0);
      tick(1'b0, '0, 1'b0);
      tick_pin(1'b0, '0, 1'b0, 15'h0200, 16'h1200);
      tick_pin(1'b0, '0, 1'b0, 15'h0200, 16'h1200);
      tick(1'b0, '0, 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic          rj;
         logic [AW-1:0] rt;
         logic          rr;
         rj = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0)
            rt = 15'h7FFC + 15'($urandom_range(0, 3));
         else
            rt = 15'($urandom());
         rr = ($urandom_range(0, 3) != 0);
         tick(rj, rt, rr);
      end

      // asynchronous reset in the middle of a stall
      repeat (3) tick(1'b0, '0, 1'b1);
      repeat (2) tick(1'b0, '0, 1'b0);
      reset_n = 1'b0;
      repeat (2) tick(1'b0, '0, 1'b0);
      reset_n = 1'b1;
      tick(1'b0, '0, 1'b1);
      tick_pin(1'b0, '0, 1'b1, 15'h0000, 16'h1000);
      tick_pin(1'b0, '0, 1'b1, 15'h0001, 16'h1001);
      tick(1'b0, '0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
`default_nettype wire
